// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (redirect > stall > sequential) and IF/ID register.
// Optional per-cycle event counters are compiled in when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        NextPCSrc,
    input  logic [31:0] br_target,
    input  logic        stall,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic        flush_id_ex
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] redirect_cnt,
    output logic [31:0] stall_cnt
`endif
);

    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;
    logic        unused_tgt_lsbs;

    // Target low bits are dropped rather than trapped; alignment faults are raised elsewhere.
    assign redirect_pc     = {br_target[31:2], 2'b00};
    assign unused_tgt_lsbs = ^br_target[1:0];
    assign pc_plus4        = pc_q + 32'd4;
    assign imem_addr       = pc_q;
    assign flush_id_ex     = NextPCSrc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            if_id_pc    <= '0;
            if_id_pc4   <= '0;
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
        end else if (NextPCSrc) begin
            // Squash the wrong-path slot; pc/pc4 are left as-is since the bubble never uses them.
            pc_q        <= redirect_pc;
            if_id_inst  <= NOP_INST;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            pc_q        <= pc_plus4;
            if_id_pc    <= pc_q;
            if_id_pc4   <= pc_plus4;
            if_id_inst  <= imem_inst;
            if_id_valid <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt    <= '0;
            redirect_cnt <= '0;
            stall_cnt    <= '0;
        end else if (NextPCSrc) begin
            if (redirect_cnt != '1) redirect_cnt <= redirect_cnt + 32'd1;
        end else if (stall) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
        end else begin
            if (fetch_cnt != '1) fetch_cnt <= fetch_cnt + 32'd1;
        end
    end
`endif

endmodule
